// File: rtl/uart_rx_ctrl.sv
// Purpose : CPU-side sequencer for the UART RX FIFO: forwards receiver bytes, prefetches the head, tracks level/overrun/timeout, raises irq.
// Latency : a FIFO write in cycle W shows as data_avail from W+3; a pop in cycle N exposes the next byte from N+3.
// Backpressure: none toward the receiver; bytes arriving while the FIFO is full are dropped and set the sticky ovr flag.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   rx_valid, rx_data   receiver byte strobe and data (passed straight to the FIFO write port)
//   fifo_*              RX FIFO interface (fifo_rddata is the registered head, one edge behind the index)
//   rd_req              CPU consume of the data register
//   rd_data, data_avail held byte and its valid flag
//   level               bytes stored, including the held one
//   thresh, irq_en      level threshold (0 disables) and enables {ovr, tmo, level}
//   ovr, ovr_clr        sticky overrun flag and its clear
//   tmo, irq            idle-timeout flag and registered interrupt
module uart_rx_ctrl #(
    parameter int AW      = 9,
    parameter int TIMEOUT = 4096
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    output logic          fifo_rst,
    output logic [7:0]    fifo_wrdata,
    output logic          fifo_wr_en,
    input  logic [7:0]    fifo_rddata,
    output logic          fifo_rd_en,
    input  logic          fifo_empty,
    input  logic          fifo_full,
    input  logic          rd_req,
    output logic [7:0]    rd_data,
    output logic          data_avail,
    output logic [AW-1:0] level,
    input  logic [AW-1:0] thresh,
    input  logic [2:0]    irq_en,
    output logic          ovr,
    input  logic          ovr_clr,
    output logic          tmo,
    output logic          irq
);

    localparam int            TW        = $clog2(TIMEOUT + 1);
    localparam logic [AW-1:0] LEVEL_MAX = {AW{1'b1}};
    localparam logic [TW-1:0] TMO_VAL   = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          hold_load;
    logic          wr_accept;
    logic [1:0]    frst_sync;
    logic [7:0]    hold_q;
    logic [TW-1:0] idle_cnt;
    logic          irq_nxt;

    // ------------------------------------------------------------------
    // FIFO reset: asserts with rst, releases on the second edge after rst
    // rises so the FIFO leaves reset cleanly synchronised to clk.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frst_sync <= 2'b00;
        end else begin
            frst_sync <= {frst_sync[0], 1'b1};
        end
    end

    assign fifo_rst = ~frst_sync[1];

    // Write path is a straight pass-through; the FIFO itself drops when full.
    assign fifo_wr_en  = rx_valid;
    assign fifo_wrdata = rx_data;
    assign wr_accept   = rx_valid & ~fifo_full;

    // ------------------------------------------------------------------
    // Read FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Read FSM: next state.  WAIT exists because fifo_rddata only reflects
    // a new head one edge after the FIFO becomes non-empty or is popped.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (!fifo_empty) state_nxt = ST_WAIT;
            ST_WAIT:  state_nxt = ST_HOLD;
            ST_HOLD:  if (rd_req) state_nxt = ST_EMPTY;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    // Read FSM: outputs.  The pop is a single-cycle pulse tied to the
    // consuming read; rd_req in any other state is ignored.
    always_comb begin
        fifo_rd_en = 1'b0;
        hold_load  = 1'b0;
        case (state)
            ST_WAIT: hold_load  = 1'b1;
            ST_HOLD: fifo_rd_en = rd_req;
            default: begin
                fifo_rd_en = 1'b0;
                hold_load  = 1'b0;
            end
        endcase
    end

    // Holding register; rd_data stays stable for the whole HOLD period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q     <= 8'h00;
            data_avail <= 1'b0;
        end else if (hold_load) begin
            hold_q     <= fifo_rddata;
            data_avail <= 1'b1;
        end else if (fifo_rd_en) begin
            data_avail <= 1'b0;
        end
    end

    assign rd_data = hold_q;

    // ------------------------------------------------------------------
    // Occupancy: a simultaneous accept and pop leaves the count unchanged.
    // Guards keep it from wrapping in either direction.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level <= '0;
        end else begin
            case ({wr_accept, fifo_rd_en})
                2'b10:   if (level != LEVEL_MAX) level <= level + AW'(1);
                2'b01:   if (level != '0)        level <= level - AW'(1);
                default: level <= level;
            endcase
        end
    end

    // Sticky overrun: a drop in the same cycle as ovr_clr keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovr <= 1'b0;
        end else if (rx_valid && fifo_full) begin
            ovr <= 1'b1;
        end else if (ovr_clr) begin
            ovr <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Idle timeout: counts cycles with data pending and no traffic in
    // either direction; parks at TIMEOUT so tmo stays up until cleared.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt <= '0;
        end else if (rx_valid || fifo_rd_en || (level == '0)) begin
            idle_cnt <= '0;
        end else if (idle_cnt != TMO_VAL) begin
            idle_cnt <= idle_cnt + TW'(1);
        end
    end

    assign tmo = (idle_cnt == TMO_VAL);

    // ------------------------------------------------------------------
    // Interrupt: registered OR of the enabled causes.
    // ------------------------------------------------------------------
    always_comb begin
        irq_nxt = (irq_en[0] && (thresh != '0) && (level >= thresh))
                | (irq_en[1] && tmo)
                | (irq_en[2] && ovr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq <= 1'b0;
        end else begin
            irq <= irq_nxt;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Purpose : self-checking bench for uart_rx_ctrl with a behavioural RX FIFO and a queue-based reference model.
// Latency : checks the W+3 / N+3 availability timing, level, overrun, timeout and irq cycle by cycle.
// Backpressure: the bench FIFO drops writes when full, as the real FIFO does.
module tb_uart_rx_ctrl;

    localparam int AW    = 9;
    localparam int TMO   = 16;
    localparam int DEPTH = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          fifo_rst;
    logic [7:0]    fifo_wrdata;
    logic          fifo_wr_en;
    logic [7:0]    fifo_rddata;
    logic          fifo_rd_en;
    logic          fifo_empty;
    logic          fifo_full;
    logic          rd_req;
    logic [7:0]    rd_data;
    logic          data_avail;
    logic [AW-1:0] level;
    logic [AW-1:0] thresh;
    logic [2:0]    irq_en;
    logic          ovr;
    logic          ovr_clr;
    logic          tmo;
    logic          irq;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.AW(AW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .fifo_rst(fifo_rst), .fifo_wrdata(fifo_wrdata), .fifo_wr_en(fifo_wr_en),
        .fifo_rddata(fifo_rddata), .fifo_rd_en(fifo_rd_en), .fifo_empty(fifo_empty),
        .fifo_full(fifo_full), .rd_req(rd_req), .rd_data(rd_data), .data_avail(data_avail),
        .level(level), .thresh(thresh), .irq_en(irq_en), .ovr(ovr), .ovr_clr(ovr_clr),
        .tmo(tmo), .irq(irq)
    );

    // Behavioural RX FIFO: registered head data, drops writes when full.
    logic [7:0]    fmem [0:(1<<AW)-1];
    logic [AW-1:0] fwp, frp;
    logic [7:0]    frd;
    int            fcount = 0;

    always @(posedge clk or posedge fifo_rst) begin
        if (fifo_rst) begin
            fwp    <= '0;
            frp    <= '0;
            frd    <= 8'h00;
            fcount <= 0;
        end else begin
            frd <= fmem[frp];
            if (fifo_wr_en && fcount < DEPTH) begin
                fmem[fwp] <= fifo_wrdata;
                fwp       <= fwp + 9'd1;
            end
            if (fifo_rd_en && fcount > 0) frp <= frp + 9'd1;
            fcount <= fcount + ((fifo_wr_en && fcount < DEPTH) ? 1 : 0)
                             - ((fifo_rd_en && fcount > 0) ? 1 : 0);
        end
    end

    assign fifo_rddata = frd;
    assign fifo_empty  = (fcount == 0);
    assign fifo_full   = (fcount == DEPTH);

    // Check bookkeeping
    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: accepted bytes with the cycle they were written.
    // A head byte becomes visible three cycles after the later of its write
    // and the previous pop.
    typedef struct {
        logic [7:0] d;
        int         wc;
    } ent_t;

    ent_t mq[$];
    int   cyc;
    int   last_pop;
    int   m_idle;
    logic m_ovr;
    logic m_irq;

    function automatic bit m_avail();
        int t;
        if (mq.size() == 0) return 1'b0;
        t = (mq[0].wc > last_pop) ? mq[0].wc : last_pop;
        return (cyc >= t + 3);
    endfunction

    task automatic model_reset();
        mq.delete();
        cyc      = 0;
        last_pop = -100;
        m_idle   = 0;
        m_ovr    = 1'b0;
        m_irq    = 1'b0;
    endtask

    task automatic model_check();
        bit av;
        av = m_avail();
        check("data_avail", data_avail, av);
        if (av) check("rd_data", rd_data, mq[0].d);
        check("level", level, mq.size());
        check("fifo_rd_en", fifo_rd_en, rd_req && av);
        check("fifo_wr_en", fifo_wr_en, rx_valid);
        check("fifo_wrdata", fifo_wrdata, rx_data);
        check("ovr", ovr, m_ovr);
        check("tmo", tmo, m_idle == TMO);
        check("irq", irq, m_irq);
    endtask

    task automatic model_step();
        int sz;
        bit full, pop, nirq;
        sz   = mq.size();
        full = (sz == DEPTH);
        pop  = rd_req && m_avail();
        nirq = (irq_en[0] && thresh != 0 && sz >= int'(thresh))
             || (irq_en[1] && m_idle == TMO)
             || (irq_en[2] && m_ovr);
        if (rx_valid && full) m_ovr = 1'b1;
        else if (ovr_clr)     m_ovr = 1'b0;
        if (rx_valid || pop || sz == 0) m_idle = 0;
        else if (m_idle < TMO)          m_idle++;
        m_irq = nirq;
        if (pop) begin
            void'(mq.pop_front());
            last_pop = cyc;
        end
        if (rx_valid && !full) mq.push_back('{rx_data, cyc});
        cyc++;
    endtask

    // One clock cycle: inputs already applied just after the previous edge.
    task automatic tick();
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rd_req   = 1'b0;
        ovr_clr  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_fifo_rst"}, fifo_rst, 1);
        check({tag, "_data_avail"}, data_avail, 0);
        check({tag, "_rd_data"}, rd_data, 0);
        check({tag, "_level"}, level, 0);
        check({tag, "_ovr"}, ovr, 0);
        check({tag, "_tmo"}, tmo, 0);
        check({tag, "_irq"}, irq, 0);
    endtask

    // Release reset just after an edge; fifo_rst must clear on the 2nd edge.
    task automatic release_reset(input string tag);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check({tag, "_fifo_rst_edge1"}, fifo_rst, 1);
        @(posedge clk); #1;
        check({tag, "_fifo_rst_edge2"}, fifo_rst, 0);
        model_reset();
    endtask

    task automatic do_reset(input string tag);
        idle_inputs();
        rst = 1'b0;
        #1;
        check_reset_outputs(tag);
        model_reset();
        release_reset(tag);
    endtask

    typedef struct {
        logic       rxv;
        logic [7:0] rxd;
        logic       rdr;
        logic       e_av;
        logic [7:0] e_rd;
        int         e_lvl;
        logic       e_rden;
    } vec_t;

    vec_t tv[20];

    initial begin
        // Single byte, then a 3-byte burst read back in order; rd_req in
        // WAIT (row 2) and EMPTY (row 11) must be ignored.
        tv[0]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 8'h00, 0, 1'b0};
        tv[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1, 1'b0};
        tv[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1, 1'b0};
        tv[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 1, 1'b0};
        tv[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h5A, 1, 1'b1};
        tv[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 0, 1'b0};
        tv[6]  = '{1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 0, 1'b0};
        tv[7]  = '{1'b1, 8'h02, 1'b0, 1'b0, 8'h00, 1, 1'b0};
        tv[8]  = '{1'b1, 8'h03, 1'b0, 1'b0, 8'h00, 2, 1'b0};
        tv[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 3, 1'b0};
        tv[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 3, 1'b1};
        tv[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 2, 1'b0};
        tv[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 2, 1'b0};
        tv[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h02, 2, 1'b0};
        tv[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h02, 2, 1'b1};
        tv[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1, 1'b0};
        tv[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1, 1'b0};
        tv[17] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 1, 1'b0};
        tv[18] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 1, 1'b1};
        tv[19] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 0, 1'b0};

        // Power-on reset
        rst    = 1'b0;
        thresh = '0;
        irq_en = 3'b000;
        idle_inputs();
        model_reset();
        #1;
        check_reset_outputs("por");
        release_reset("por");

        // Table-driven single byte and burst
        for (int i = 0; i < 20; i++) begin
            rx_valid = tv[i].rxv;
            rx_data  = tv[i].rxd;
            rd_req   = tv[i].rdr;
            @(negedge clk);
            check($sformatf("tbl%0d_avail", i), data_avail, tv[i].e_av);
            if (tv[i].e_av) check($sformatf("tbl%0d_rd_data", i), rd_data, tv[i].e_rd);
            check($sformatf("tbl%0d_level", i), level, tv[i].e_lvl);
            check($sformatf("tbl%0d_rd_en", i), fifo_rd_en, tv[i].e_rden);
            model_check();
            @(posedge clk);
            model_step();
            #1;
        end
        idle_inputs();

        // Fill to depth, then one more byte overruns
        irq_en = 3'b100;
        for (int i = 0; i < DEPTH; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'(i);
            tick();
        end
        check("full_level", level, DEPTH);
        check("full_flag", fifo_full, 1);
        check("full_ovr_pre", ovr, 0);
        rx_data = 8'hEE;
        tick();
        idle_inputs();
        check("ovr_set", ovr, 1);
        check("ovr_level_sat", level, DEPTH);
        check("ovr_irq_pre", irq, 0);
        tick();
        check("ovr_irq", irq, 1);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check("ovr_clr", ovr, 0);
        do_reset("rst_after_ovr");

        // Idle timeout with one pending byte
        irq_en   = 3'b010;
        rx_valid = 1'b1;
        rx_data  = 8'hC3;
        tick();
        idle_inputs();
        repeat (15) tick();
        check("tmo_before", tmo, 0);
        tick();
        check("tmo_set", tmo, 1);
        check("tmo_irq_pre", irq, 0);
        tick();
        check("tmo_irq", irq, 1);
        check("tmo_avail", data_avail, 1);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check("tmo_clr", tmo, 0);
        check("tmo_level", level, 0);

        // Level threshold interrupt
        thresh = 9'd4;
        irq_en = 3'b001;
        for (int i = 0; i < 4; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'h10 + 8'(i);
            tick();
        end
        idle_inputs();
        check("thr_level4", level, 4);
        check("thr_irq_pre", irq, 0);
        tick();
        check("thr_irq", irq, 1);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check("thr_level3", level, 3);
        check("thr_irq_hold", irq, 1);
        tick();
        check("thr_irq_fall", irq, 0);

        // Reset while holding a byte with level 5
        for (int i = 0; i < 2; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'h20 + 8'(i);
            tick();
        end
        idle_inputs();
        check("pre_rst_level", level, 5);
        check("pre_rst_avail", data_avail, 1);
        do_reset("mid_rst");
        check("post_rst_empty", fifo_empty, 1);
        check("post_rst_avail", data_avail, 0);
        repeat (4) tick();

        // Randomised traffic against the reference model
        for (int blk = 0; blk < 12; blk++) begin
            int prx, prd;
            bit quiet;
            quiet  = (blk % 3 == 2);
            prx    = quiet ? 2 : int'($urandom_range(10, 60));
            prd    = quiet ? 2 : int'($urandom_range(10, 70));
            thresh = 9'($urandom_range(0, 8));
            irq_en = 3'($urandom_range(0, 7));
            for (int c = 0; c < 250; c++) begin
                rx_valid = ($urandom_range(0, 99) < prx);
                rx_data  = 8'($urandom);
                rd_req   = ($urandom_range(0, 99) < prd);
                ovr_clr  = ($urandom_range(0, 99) < 3);
                tick();
            end
        end
        idle_inputs();
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
